// File: rtl/fwd_hazard_unit_if.sv
// IF/ID decode fields in, EX forwarding selects and load-use stall out.
// The ID side drives instruction fields; the hazard unit returns stall and selects.
interface fwd_hazard_unit_if #(
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic [5:0]       id_op;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic [4:0]       id_rd;
   logic             flush;
   logic             stall;
   logic [1:0]       fa;
   logic [1:0]       fb;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_valid, id_op, id_rs, id_rt, id_rd, flush,
      input  stall, fa, fb, stall_count
   );

   modport slave (
      input  id_valid, id_op, id_rs, id_rt, id_rd, flush,
      output stall, fa, fb, stall_count
   );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding selects and load-use stall for the EX-stage ALU operand muxes.
// fa/fb registered, valid one clock after ID; stall is combinational and holds IF/ID one cycle.
module fwd_hazard_unit #(
   parameter logic [5:0] ALU_OP  = 6'd0,
   parameter logic [5:0] J_OP    = 6'd2,
   parameter logic [5:0] JAL_OP  = 6'd3,
   parameter logic [5:0] BEQ_OP  = 6'd4,
   parameter logic [5:0] ADDI_OP = 6'd8,
   parameter logic [5:0] LW_OP   = 6'd35,
   parameter logic [5:0] SW_OP   = 6'd43,
   parameter int         CNT_W   = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   fwd_hazard_unit_if.slave  bus
);

   typedef struct packed {
      logic       valid;
      logic [4:0] dest;
      logic       wr;
      logic       is_load;
   } ex_slot_t;

   // Past EX the load flag no longer matters, so the MEM slot drops it.
   // The WB slot is not kept: nothing downstream of MEM feeds a select or a stall.
   typedef struct packed {
      logic       valid;
      logic [4:0] dest;
      logic       wr;
   } mem_slot_t;

   ex_slot_t         ex_slot;
   mem_slot_t        mem_slot;
   ex_slot_t         dec_slot;
   logic [1:0]       fa_q;
   logic [1:0]       fb_q;
   logic [CNT_W-1:0] cnt_q;

   logic       uses_rs;
   logic       uses_rt;
   logic       has_dest;
   logic       is_load;
   logic [4:0] dec_dest;
   logic       hazard;
   logic       stall_int;
   logic       ex_load;
   logic [1:0] fa_nxt;
   logic [1:0] fb_nxt;

   always_comb begin
      uses_rs  = 1'b0;
      uses_rt  = 1'b0;
      has_dest = 1'b0;
      is_load  = 1'b0;
      dec_dest = 5'd0;
      if (bus.id_valid) begin
         case (bus.id_op)
            ALU_OP: begin
               dec_dest = bus.id_rd;
               has_dest = 1'b1;
               uses_rs  = 1'b1;
               uses_rt  = 1'b1;
            end
            J_OP: ;
            JAL_OP: begin
               dec_dest = 5'd31;
               has_dest = 1'b1;
            end
            BEQ_OP, SW_OP: begin
               uses_rs = 1'b1;
               uses_rt = 1'b1;
            end
            ADDI_OP: begin
               dec_dest = bus.id_rt;
               has_dest = 1'b1;
               uses_rs  = 1'b1;
            end
            LW_OP: begin
               dec_dest = bus.id_rt;
               has_dest = 1'b1;
               uses_rs  = 1'b1;
               is_load  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      dec_slot.valid   = 1'b1;
      dec_slot.dest    = dec_dest;
      dec_slot.wr      = has_dest && (dec_dest != 5'd0);
      dec_slot.is_load = is_load;
   end

   // A zero dest clears wr, so r0 can never match here or in the selects below.
   assign hazard = bus.id_valid && ex_slot.valid && ex_slot.is_load && ex_slot.wr &&
                   ((uses_rs && (ex_slot.dest == bus.id_rs)) ||
                    (uses_rt && (ex_slot.dest == bus.id_rt)));
   assign stall_int = hazard && !bus.flush;
   assign ex_load   = bus.id_valid && !stall_int && !bus.flush;

   always_comb begin
      fa_nxt = 2'b00;
      fb_nxt = 2'b00;
      if (uses_rs && ex_slot.valid && ex_slot.wr && (ex_slot.dest == bus.id_rs))
         fa_nxt = 2'b10;
      else if (uses_rs && mem_slot.valid && mem_slot.wr && (mem_slot.dest == bus.id_rs))
         fa_nxt = 2'b01;
      if (uses_rt && ex_slot.valid && ex_slot.wr && (ex_slot.dest == bus.id_rt))
         fb_nxt = 2'b10;
      else if (uses_rt && mem_slot.valid && mem_slot.wr && (mem_slot.dest == bus.id_rt))
         fb_nxt = 2'b01;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         ex_slot  <= '0;
         mem_slot <= '0;
         fa_q     <= 2'b00;
         fb_q     <= 2'b00;
         cnt_q    <= '0;
      end else begin
         mem_slot.valid <= ex_slot.valid;
         mem_slot.dest  <= ex_slot.dest;
         mem_slot.wr    <= ex_slot.wr;
         if (ex_load) begin
            ex_slot <= dec_slot;
            fa_q    <= fa_nxt;
            fb_q    <= fb_nxt;
         end else begin
            ex_slot <= '0;
            fa_q    <= 2'b00;
            fb_q    <= 2'b00;
         end
         if (stall_int && (cnt_q != {CNT_W{1'b1}}))
            cnt_q <= cnt_q + 1'b1;
      end
   end

   assign bus.stall       = stall_int;
   assign bus.fa          = fa_q;
   assign bus.fb          = fb_q;
   assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Random and directed instruction streams checked against a register-level model of forwarding and stalls.
module tb_fwd_hazard_unit;
   // Narrow counter keeps the saturation run short.
   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   fwd_hazard_unit_if #(.CNT_W(CNT_W)) bus ();
   fwd_hazard_unit #(.CNT_W(CNT_W)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

   int n_tests = 0;
   int n_fail  = 0;

   // Model: destination register of the instruction now in EX / MEM (0 = no forwardable result).
   int m_ex   = 0;
   int m_mem  = 0;
   bit m_exld = 0;
   int m_cnt  = 0;
   bit last_stall = 0;
   int obs_stall  = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int dest_of(input int op, input int rt, input int rd);
      case (op)
         0:       return rd;
         3:       return 31;
         8, 35:   return rt;
         default: return 0;
      endcase
   endfunction

   function automatic bit reads_rs(input int op);
      return op inside {0, 4, 8, 35, 43};
   endfunction

   function automatic bit reads_rt(input int op);
      return op inside {0, 4, 43};
   endfunction

   function automatic int sel(input bit used, input int r);
      if (!used || r == 0) return 0;
      if (r == m_ex)       return 2;
      if (r == m_mem)      return 1;
      return 0;
   endfunction

   task automatic model_reset();
      m_ex = 0; m_mem = 0; m_exld = 0; m_cnt = 0; last_stall = 0;
   endtask

   // One clock: present ID inputs, check stall mid-cycle, check registered outputs after the edge.
   task automatic step(input bit v, input int op, input int rs, input int rt, input int rd, input bit fl);
      bit urs, urt, hz, st, enter;
      int efa, efb;
      bus.id_valid = v;
      bus.id_op    = 6'(op);
      bus.id_rs    = 5'(rs);
      bus.id_rt    = 5'(rt);
      bus.id_rd    = 5'(rd);
      bus.flush    = fl;
      #4;
      urs = v && reads_rs(op);
      urt = v && reads_rt(op);
      hz  = v && m_exld && m_ex != 0 && ((urs && rs == m_ex) || (urt && rt == m_ex));
      st  = hz && !fl;
      obs_stall = int'(bus.stall);
      check("stall", obs_stall, int'(st));
      enter = v && !st && !fl;
      efa = enter ? sel(urs, rs) : 0;
      efb = enter ? sel(urt, rt) : 0;
      m_mem  = m_ex;
      m_ex   = enter ? dest_of(op, rt, rd) : 0;
      m_exld = enter && op == 35;
      if (st && m_cnt < CNT_MAX) m_cnt++;
      last_stall = st;
      @(posedge clock);
      #1;
      check("fa", int'(bus.fa), efa);
      check("fb", int'(bus.fb), efb);
      check("stall_count", int'(bus.stall_count), m_cnt);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      bus.id_valid = 1'b0;
      bus.flush    = 1'b0;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      model_reset();
      check("rst_fa", int'(bus.fa), 0);
      check("rst_fb", int'(bus.fb), 0);
      check("rst_cnt", int'(bus.stall_count), 0);
   endtask

   initial begin
      int ops[8] = '{0, 2, 3, 4, 8, 35, 43, 17};
      int op, rs, rt, rd;
      bit v, fl;
      reset_n = 1'b0;
      bus.id_valid = 1'b0; bus.id_op = '0; bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
      bus.flush = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      do_reset();
      #4;
      check("rst_stall", int'(bus.stall), 0);
      @(posedge clock);
      #1;

      // Back-to-back ALU dependency
      step(1, 0, 1, 2, 3, 0);
      step(1, 0, 3, 5, 4, 0);
      check("bb_fa", int'(bus.fa), 2);
      check("bb_fb", int'(bus.fb), 0);
      check("bb_stall", obs_stall, 0);

      // Gap of one
      step(1, 0, 1, 2, 3, 0);
      step(0, 0, 0, 0, 0, 0);
      step(1, 0, 7, 3, 6, 0);
      check("gap_fa", int'(bus.fa), 0);
      check("gap_fb", int'(bus.fb), 1);

      // Double producer: youngest wins
      step(1, 8, 1, 3, 0, 0);
      step(1, 0, 1, 2, 3, 0);
      step(1, 0, 3, 3, 8, 0);
      check("dbl_fa", int'(bus.fa), 2);
      check("dbl_fb", int'(bus.fb), 2);

      // Load-use
      do_reset();
      step(1, 35, 1, 2, 0, 0);
      step(1, 0, 2, 2, 4, 0);
      check("lu_stall", obs_stall, 1);
      check("lu_bub_fa", int'(bus.fa), 0);
      check("lu_bub_fb", int'(bus.fb), 0);
      step(1, 0, 2, 2, 4, 0);
      check("lu_stall2", obs_stall, 0);
      check("lu_fa", int'(bus.fa), 1);
      check("lu_fb", int'(bus.fb), 1);
      check("lu_cnt", int'(bus.stall_count), 1);

      // Hazard with flush
      do_reset();
      step(1, 35, 1, 2, 0, 0);
      step(1, 0, 2, 2, 4, 1);
      check("fl_stall", obs_stall, 0);
      check("fl_cnt", int'(bus.stall_count), 0);
      check("fl_fa", int'(bus.fa), 0);
      step(0, 0, 0, 0, 0, 0);

      // r0 never forwarded nor stalled on
      step(1, 0, 1, 2, 0, 0);
      step(1, 0, 0, 0, 5, 0);
      check("r0_fa", int'(bus.fa), 0);
      check("r0_fb", int'(bus.fb), 0);
      step(1, 35, 1, 0, 0, 0);
      step(1, 0, 0, 0, 6, 0);
      check("r0_ld_stall", obs_stall, 0);

      // Reset during a stall cycle
      do_reset();
      step(1, 35, 1, 2, 0, 0);
      bus.id_valid = 1'b1; bus.id_op = 6'd0; bus.id_rs = 5'd2; bus.id_rt = 5'd2; bus.id_rd = 5'd4;
      #4;
      check("rs_pre_stall", int'(bus.stall), 1);
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      model_reset();
      check("rs_fa", int'(bus.fa), 0);
      check("rs_fb", int'(bus.fb), 0);
      check("rs_cnt", int'(bus.stall_count), 0);
      step(1, 0, 2, 2, 4, 0);
      check("rs_stall", obs_stall, 0);

      // Random streams; a stalled instruction is re-presented
      do_reset();
      op = 0; rs = 0; rt = 0; rd = 0; v = 0;
      for (int i = 0; i < 1500; i++) begin
         if (!last_stall) begin
            v  = ($urandom_range(0, 9) != 0);
            op = ops[$urandom_range(0, 7)];
            rs = $urandom_range(0, 5);
            rt = $urandom_range(0, 5);
            rd = $urandom_range(0, 5);
         end
         fl = ($urandom_range(0, 11) == 0);
         step(v, op, rs, rt, rd, fl);
      end

      // Counter saturation with a chain of dependent loads
      do_reset();
      for (int i = 0; i < 2 * (CNT_MAX + 20); i++)
         step(1, 35, 2, 2, 0, 0);
      check("sat_cnt", int'(bus.stall_count), CNT_MAX);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
